// File: rtl/mem_sram_ctrl.sv
// Memory-side responder: executes mem_rd/mem_wr requests on a 16-bit async SRAM with byte lanes.
// 32-bit requests become two halfword accesses; all SRAM strobes come straight from flops.
module mem_sram_ctrl #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [25:0]       mem_addr,
    input  logic [1:0]        mem_data_width,
    input  logic [31:0]       mem_wr_data,
    output logic              mem_rd_ready,
    output logic              mem_wr_ready,
    output logic              mem_rd_valid,
    output logic [31:0]       mem_rd_data,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);
    localparam int unsigned CNT_W = 4;
    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_8    = 2'b01;
    localparam logic [1:0] W_16   = 2'b10;
    localparam logic [1:0] W_32   = 2'b11;

    typedef enum logic [1:0] {IDLE, RD_ACC, WR_ACC, WR_HOLD} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              second_q, second_d;
    logic [1:0]        width_q, width_d;
    logic              byte_hi_q, byte_hi_d;
    logic [15:0]       lo_q, lo_d;
    logic [15:0]       wr_hi_q, wr_hi_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;

    logic              idle_c;
    logic              last_c;
    logic [ADDR_W-1:0] req_hw_c;
    logic              unused_addr_c;

    assign idle_c        = (state_q == IDLE) & ~rst;
    assign mem_rd_ready  = idle_c;
    assign mem_wr_ready  = idle_c;
    assign last_c        = (cnt_q == CNT_W'(WAIT_CYCLES));
    // 32-bit requests always start on the even halfword
    assign req_hw_c      = (mem_data_width == W_32) ? {mem_addr[ADDR_W:2], 1'b0}
                                                    : mem_addr[ADDR_W:1];
    assign unused_addr_c = ^mem_addr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        second_d   = second_q;
        width_d    = width_q;
        byte_hi_d  = byte_hi_q;
        lo_d       = lo_q;
        wr_hi_d    = wr_hi_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;

        case (state_q)
            IDLE: begin
                if (mem_rd || mem_wr) begin
                    width_d   = mem_data_width;
                    byte_hi_d = mem_addr[0];
                    cnt_d     = '0;
                    second_d  = 1'b0;
                    if (mem_data_width != W_NONE) addr_d = req_hw_c;
                end
                // read wins when both are requested; the write is dropped
                if (mem_rd) begin
                    if (mem_data_width == W_NONE) begin
                        rd_data_d  = '0;
                        rd_valid_d = 1'b1;
                    end else begin
                        state_d = RD_ACC;
                    end
                end else if (mem_wr && (mem_data_width != W_NONE)) begin
                    state_d = WR_ACC;
                    wr_hi_d = mem_wr_data[31:16];
                    dq_o_d  = (mem_data_width == W_8) ? {2{mem_wr_data[7:0]}}
                                                      : mem_wr_data[15:0];
                end
            end
            RD_ACC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last_c) begin
                    cnt_d = '0;
                    if ((width_q == W_32) && !second_q) begin
                        second_d = 1'b1;
                        lo_d     = sram_dq_i;
                        addr_d   = addr_q + ADDR_W'(1);
                    end else begin
                        rd_valid_d = 1'b1;
                        state_d    = IDLE;
                        case (width_q)
                            W_8:     rd_data_d = {24'h0, byte_hi_q ? sram_dq_i[15:8] : sram_dq_i[7:0]};
                            W_16:    rd_data_d = {16'h0, sram_dq_i};
                            default: rd_data_d = {sram_dq_i, lo_q};
                        endcase
                    end
                end
            end
            WR_ACC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last_c) begin
                    cnt_d   = '0;
                    state_d = WR_HOLD;
                end
            end
            WR_HOLD: begin
                if ((width_q == W_32) && !second_q) begin
                    second_d = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
                    dq_o_d   = wr_hi_q;
                    state_d  = WR_ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // strobes follow the state being entered so they are valid for the whole access
        ce_n_d  = (state_d == IDLE);
        oe_n_d  = (state_d != RD_ACC);
        we_n_d  = (state_d != WR_ACC);
        dq_oe_d = (state_d == WR_ACC) || (state_d == WR_HOLD);
        if (state_d == IDLE) begin
            ub_n_d = 1'b1;
            lb_n_d = 1'b1;
        end else if (width_d == W_8) begin
            ub_n_d = ~byte_hi_d;
            lb_n_d = byte_hi_d;
        end else begin
            ub_n_d = 1'b0;
            lb_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            second_q   <= 1'b0;
            width_q    <= W_NONE;
            byte_hi_q  <= 1'b0;
            lo_q       <= '0;
            wr_hi_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            second_q   <= second_d;
            width_q    <= width_d;
            byte_hi_q  <= byte_hi_d;
            lo_q       <= lo_d;
            wr_hi_q    <= wr_hi_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_q     <= addr_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
        end
    end

    assign mem_rd_valid = rd_valid_q;
    assign mem_rd_data  = rd_data_q;
    assign sram_addr    = addr_q;
    assign sram_dq_o    = dq_o_q;
    assign sram_dq_oe   = dq_oe_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign sram_ub_n    = ub_n_q;
    assign sram_lb_n    = lb_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a small byte-lane SRAM model.
module tb_mem_sram_ctrl;
    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [25:0] mem_addr;
    logic [1:0]  mem_data_width;
    logic [31:0] mem_wr_data;
    logic        mem_rd_ready;
    logic        mem_wr_ready;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    logic [15:0] mem [256];
    int          n_checks;
    int          n_errors;
    int          n_hyg;

    mem_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_width (mem_data_width),
        .mem_wr_data    (mem_wr_data),
        .mem_rd_ready   (mem_rd_ready),
        .mem_wr_ready   (mem_wr_ready),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .sram_addr      (sram_addr),
        .sram_dq_i      (sram_dq_i),
        .sram_dq_o      (sram_dq_o),
        .sram_dq_oe     (sram_dq_oe),
        .sram_ce_n      (sram_ce_n),
        .sram_oe_n      (sram_oe_n),
        .sram_we_n      (sram_we_n),
        .sram_ub_n      (sram_ub_n),
        .sram_lb_n      (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: lane-masked write while ce_n/we_n low, combinational read while oe_n low
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_o[7:0];
        end
    end

    always @(negedge clk) begin
        if ((!sram_oe_n && !sram_we_n) || (sram_dq_oe && !sram_oe_n)) n_hyg++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch the SRAM pins until completion (valid for reads, ready for writes)
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [25:0] a, input logic [1:0] w, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rd, input int exp_we,
                           output int n_ce, output logic [19:0] first_addr,
                           output logic [1:0] first_lanes);
        int lat;
        int n_we;
        int n_valid;
        int early_ready;
        bit seen;
        lat = 0; n_we = 0; n_valid = 0; early_ready = 0; seen = 0; n_ce = 0;
        first_addr = '0; first_lanes = 2'b11;
        @(negedge clk);
        check({tag, " ready"}, 32'(mem_rd_ready & mem_wr_ready), 32'd1);
        mem_rd = rd; mem_wr = wr; mem_addr = a; mem_data_width = w; mem_wr_data = wd;
        @(posedge clk);
        #1;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 26'h3FFFFFF;
        mem_data_width = 2'b11; mem_wr_data = 32'hDEADDEAD;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!sram_we_n) n_we++;
            if (!sram_ce_n) begin
                n_ce++;
                if (!seen) begin
                    seen        = 1;
                    first_addr  = sram_addr;
                    first_lanes = {sram_ub_n, sram_lb_n};
                end
            end
            if (mem_rd_valid) n_valid++;
            if (lat == 0) begin
                if (rd ? mem_rd_valid : mem_rd_ready) lat = i;
                else if (mem_rd_ready) early_ready++;
            end
            if (lat != 0 && i >= lat + 1) break;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " we_cycles"}, 32'(n_we), 32'(exp_we));
        if (rd) begin
            check({tag, " data"}, mem_rd_data, exp_rd);
            check({tag, " valid_pulses"}, 32'(n_valid), 32'd1);
            check({tag, " early_ready"}, 32'(early_ready), 32'd0);
        end
    endtask

    int          nce;
    logic [19:0] fa;
    logic [1:0]  fl;

    initial begin
        n_checks = 0; n_errors = 0; n_hyg = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0;
        mem_data_width = 2'b00; mem_wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst valid", 32'(mem_rd_valid), 32'd0);
        check("rst rd_data", mem_rd_data, 32'd0);
        check("rst strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        check("rst dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst addr", 32'(sram_addr), 32'd0);
        check("rst dq_o", 32'(sram_dq_o), 32'd0);
        check("rst ready_low", 32'(mem_rd_ready | mem_wr_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 16-bit write then read back
        run_req("wr16", 1'b0, 1'b1, 26'h000010, 2'b10, 32'h0000BEEF, 5, 32'h0, 3, nce, fa, fl);
        check("wr16 addr", 32'(fa), 32'h8);
        check("wr16 lanes", 32'(fl), 32'h0);
        check("wr16 mem", 32'(mem[8'h08]), 32'hBEEF);
        run_req("rd16", 1'b1, 1'b0, 26'h000010, 2'b10, 32'h0, 4, 32'h0000BEEF, 0, nce, fa, fl);
        check("rd16 addr", 32'(fa), 32'h8);
        check("rd16 lanes", 32'(fl), 32'h0);

        // byte lanes
        run_req("wr8lo", 1'b0, 1'b1, 26'h000020, 2'b01, 32'h0000003C, 5, 32'h0, 3, nce, fa, fl);
        check("wr8lo lanes", 32'(fl), 32'h2);
        run_req("wr8hi", 1'b0, 1'b1, 26'h000021, 2'b01, 32'h000000A5, 5, 32'h0, 3, nce, fa, fl);
        check("wr8hi addr", 32'(fa), 32'h10);
        check("wr8hi lanes", 32'(fl), 32'h1);
        check("wr8 mem", 32'(mem[8'h10]), 32'hA53C);
        run_req("rd8hi", 1'b1, 1'b0, 26'h000021, 2'b01, 32'h0, 4, 32'h000000A5, 0, nce, fa, fl);
        check("rd8hi lanes", 32'(fl), 32'h1);
        run_req("rd8lo", 1'b1, 1'b0, 26'h000020, 2'b01, 32'h0, 4, 32'h0000003C, 0, nce, fa, fl);
        run_req("rd16odd", 1'b1, 1'b0, 26'h000021, 2'b10, 32'h0, 4, 32'h0000A53C, 0, nce, fa, fl);
        check("rd16odd addr", 32'(fa), 32'h10);

        // 32-bit split into two halfwords
        run_req("wr32", 1'b0, 1'b1, 26'h000042, 2'b11, 32'h12345678, 9, 32'h0, 6, nce, fa, fl);
        check("wr32 addr", 32'(fa), 32'h20);
        check("wr32 mem_lo", 32'(mem[8'h20]), 32'h5678);
        check("wr32 mem_hi", 32'(mem[8'h21]), 32'h1234);
        run_req("rd32", 1'b1, 1'b0, 26'h000040, 2'b11, 32'h0, 7, 32'h12345678, 0, nce, fa, fl);
        check("rd32 ce_cycles", 32'(nce), 32'd6);

        // writes leave the read data register alone
        run_req("wr16b", 1'b0, 1'b1, 26'h000002, 2'b10, 32'h00004321, 5, 32'h0, 3, nce, fa, fl);
        check("hold rd_data", mem_rd_data, 32'h12345678);

        // upper address bits wrap
        run_req("rdwrap", 1'b1, 1'b0, 26'h3E00010, 2'b10, 32'h0, 4, 32'h0000BEEF, 0, nce, fa, fl);

        // simultaneous read and write: only the read happens
        run_req("rdwr", 1'b1, 1'b1, 26'h000100, 2'b10, 32'h00007777, 4, 32'h0000FFFF, 0, nce, fa, fl);
        check("rdwr addr", 32'(fa), 32'h80);
        check("rdwr mem", 32'(mem[8'h80]), 32'hFFFF);

        // width 00: no bus cycle
        run_req("rd0", 1'b1, 1'b0, 26'h000010, 2'b00, 32'h0, 1, 32'h0, 0, nce, fa, fl);
        check("rd0 ce_cycles", 32'(nce), 32'd0);
        run_req("wr0", 1'b0, 1'b1, 26'h000010, 2'b00, 32'h1111, 1, 32'h0, 0, nce, fa, fl);
        check("wr0 ce_cycles", 32'(nce), 32'd0);
        check("wr0 mem", 32'(mem[8'h08]), 32'hBEEF);

        // reset during the second halfword of a 32-bit read
        @(negedge clk);
        mem_rd = 1'b1; mem_addr = 26'h000040; mem_data_width = 2'b11;
        @(posedge clk);
        #1 mem_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rstmid second_half", 32'({sram_oe_n, sram_ce_n, 12'h0, sram_addr}), 32'h21);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        check("rstmid dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rstmid ready", 32'(mem_rd_ready & mem_wr_ready), 32'd1);
        begin
            int nv;
            nv = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (mem_rd_valid) nv++;
            end
            check("rstmid no_valid", 32'(nv), 32'd0);
        end
        check("rstmid rd_data", mem_rd_data, 32'h0);

        check("bus hygiene", 32'(n_hyg), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
